// File: rtl/multifunction_divider32.sv
// Multi-cycle radix-2 restoring divider with RISC-V DIV/DIVU/REM/REMU semantics.
// Optional macro DIV_KILL_EN adds a kill input that aborts an in-flight operation.
module multifunction_divider32 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_dividend,
  input  logic [WIDTH-1:0] in_divisor,
  input  logic             in_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_quotient,
  output logic [WIDTH-1:0] out_remainder,
  output logic             out_div_by_zero,
  output logic             out_overflow
`ifdef DIV_KILL_EN
  ,
  input  logic             kill
`endif
);

  localparam int unsigned CW = $clog2(WIDTH);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] PREP = 3'd1;
  localparam logic [2:0] ITER = 3'd2;
  localparam logic [2:0] FIX  = 3'd3;
  localparam logic [2:0] DONE = 3'd4;

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [2:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH:0]   r_q, r_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             signed_q, signed_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;
  logic             ovf_q, ovf_d;

  logic             kill_w;
`ifdef DIV_KILL_EN
  assign kill_w = kill;
`else
  assign kill_w = 1'b0;
`endif

  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH-1:0] step_q, step_b, q_next;
  logic [WIDTH:0]   step_r, r_shift, trial, r_next;

  assign mag_a = (signed_q && a_q[WIDTH-1]) ? -a_q : a_q;
  assign mag_b = (signed_q && b_q[WIDTH-1]) ? -b_q : b_q;

  // PREP performs the first restoring step on the magnitudes, so ITER needs
  // only WIDTH-1 cycles and the total latency stays at WIDTH+2 edges.
  assign step_r  = (state_q == PREP) ? '0    : r_q;
  assign step_q  = (state_q == PREP) ? mag_a : a_q;
  assign step_b  = (state_q == PREP) ? mag_b : b_q;
  assign r_shift = {step_r[WIDTH-1:0], step_q[WIDTH-1]};
  assign trial   = r_shift - {1'b0, step_b};
  assign r_next  = trial[WIDTH] ? r_shift : trial;
  assign q_next  = {step_q[WIDTH-2:0], ~trial[WIDTH]};

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    r_d      = r_q;
    cnt_d    = cnt_q;
    signed_d = signed_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    quot_d   = quot_q;
    rem_d    = rem_q;
    dbz_d    = dbz_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid && !kill_w) begin
          a_d      = in_dividend;
          b_d      = in_divisor;
          signed_d = in_signed;
          state_d  = PREP;
        end
      end
      PREP: begin
        qneg_d = signed_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
        rneg_d = signed_q & a_q[WIDTH-1];
        if (b_q == '0) begin
          quot_d  = '1;
          rem_d   = a_q;
          dbz_d   = 1'b1;
          ovf_d   = 1'b0;
          state_d = DONE;
        end else if (signed_q && (a_q == MIN_NEG) && (b_q == '1)) begin
          quot_d  = MIN_NEG;
          rem_d   = '0;
          dbz_d   = 1'b0;
          ovf_d   = 1'b1;
          state_d = DONE;
        end else begin
          dbz_d   = 1'b0;
          ovf_d   = 1'b0;
          r_d     = r_next;
          a_d     = q_next;
          b_d     = mag_b;
          cnt_d   = CW'(1);
          state_d = ITER;
        end
      end
      ITER: begin
        r_d   = r_next;
        a_d   = q_next;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH-1)) state_d = FIX;
      end
      FIX: begin
        quot_d  = qneg_q ? -a_q : a_q;
        rem_d   = rneg_q ? -r_q[WIDTH-1:0] : r_q[WIDTH-1:0];
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (kill_w && state_q != IDLE) state_d = IDLE;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      r_q      <= '0;
      cnt_q    <= '0;
      signed_q <= 1'b0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      quot_q   <= '0;
      rem_q    <= '0;
      dbz_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      r_q      <= r_d;
      cnt_q    <= cnt_d;
      signed_q <= signed_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      quot_q   <= quot_d;
      rem_q    <= rem_d;
      dbz_q    <= dbz_d;
      ovf_q    <= ovf_d;
    end
  end

  assign in_ready        = (state_q == IDLE);
  assign out_valid       = (state_q == DONE);
  assign out_quotient    = quot_q;
  assign out_remainder   = rem_q;
  assign out_div_by_zero = dbz_q;
  assign out_overflow    = ovf_q;

endmodule
